vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Downstream checker for the VGA timing generator: consumes h_sync, v_sync and RGB exactly as driven to the connector.
- Measures line period, hsync width, lines per frame and vsync width, and checks that RGB is black during sync.
- Reports lock status, sticky error flags, a per-frame pulse and a good-frame counter.
- Used in the same bench and on-chip as a self-check of the timing generator.

Parameters:
- H_TOTAL, 800: expected clocks between successive h_sync falling edges.
- H_SYNC_W, 96: expected h_sync low width in clocks.
- V_TOTAL, 525: expected h_sync falling edges between successive v_sync falling edges.
- V_SYNC_W, 2: expected h_sync falling edges counted while v_sync is low.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- h_sync  in  1  horizontal sync, active low
- v_sync  in  1  vertical sync, active low
- RGB  in  3  pixel colour
- err_clr  in  1  clears err_flags for one cycle; its priority is defined under Behaviour
- locked  out  1  timing matches parameters for the last full frame
- frame_pulse  out  1  one-cycle pulse at each v_sync falling edge that closes a measured frame
- err_flags  out  5  sticky: [0] line period, [1] hsync width, [2] frame lines, [3] vsync width, [4] RGB non-black during sync
- frame_count  out  16  good frames seen while locked; wraps at 65535 to 0
- last_line_len  out  12  last measured line period in clocks
- last_frame_lines  out  11  last measured lines per frame

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - Registered copies h_d and v_d = 1.
  - All counters, all outputs and err_flags = 0.
  - State = SEARCH.
  - hv (h period valid) = 0.
- Edge detection:
  - h_fall = h_d & ~h_sync; h_rise = ~h_d & h_sync.
  - v_fall and v_rise are defined the same way on v_sync.
  - Edges are evaluated in the same cycle the input changes; all outputs are registered, so they update 1 clock later.
- Horizontal measurement:
  - hcnt (12 b) increments every cycle and saturates at 4095.
  - On h_fall: last_line_len <= hcnt+1 and hcnt <= 0.
  - If hv=1 on h_fall and hcnt+1 != H_TOTAL, flag err0. Then set hv <= 1.
  - hwcnt counts cycles while h_sync=0. On h_rise, flag err1 if hwcnt != H_SYNC_W; hwcnt then clears.
  - The width check is skipped if no h_fall has been seen since reset.
- Vertical measurement:
  - vline (11 b, saturating at 2047) increments on h_fall.
  - On v_fall: last_frame_lines <= vline, then vline <= 0.
  - If h_fall coincides with v_fall, vline <= 1 instead; that edge belongs to the new frame.
  - vwcnt counts h_fall while v_sync=0. On v_rise, flag err3 if vwcnt != V_SYNC_W.
- Blank check: RGB != 0 while (h_sync=0 or v_sync=0) flags err4, every cycle, in every state except SEARCH.
- State machine:
  - SEARCH: wait for v_fall, then go to ACQUIRE and clear the per-frame error accumulator fe. No frame_pulse is issued.
  - ACQUIRE: any check failure sets fe.
    - On v_fall: issue frame_pulse.
    - The frame is good if fe=0 and vline (before clear) == V_TOTAL; in that case go to LOCKED and set locked=1.
    - Otherwise, if vline != V_TOTAL, flag err2 and stay in ACQUIRE.
    - fe clears on every v_fall.
  - LOCKED: any check failure immediately sets locked=0 and moves to ACQUIRE.
    - On v_fall with no failure: frame_pulse=1 and frame_count increments.
- err_flags:
  - A flag is set when its check fails, in ACQUIRE or LOCKED.
  - When err_clr=1, err_flags <= the flags that are newly set in that same cycle; set has priority.
- Mid-operation reset: all state returns to reset values on the next edge regardless of the current state.

Optional Feature:
- Macro: VGA_MON_ACTIVE_CNT_EN.
- Defined:
  - Adds output active_pix_cnt (20 b): the number of cycles with RGB != 0 in the last completed frame.
  - An internal counter clears on v_fall after being copied to active_pix_cnt; it saturates at 2^20-1.
  - For a colour of 3'b011 over a 640x480 active area, the expected value is 307200.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Ideal timing (800/96/525/2, RGB=3'b011 only in the 640x480 active area, black elsewhere) for 3 frames:
  - locked=1 from the cycle after the 2nd v_fall.
  - frame_count=1 after the 3rd v_fall.
  - err_flags=0, last_line_len=800, last_frame_lines=525.
- While locked, shorten one line to 799 clocks:
  - err_flags[0]=1 and locked=0 one cycle after that h_fall.
  - The next clean frame relocks.
  - frame_count does not increment for the bad frame.
- While locked, drive RGB=3'b011 during one h_sync low cycle:
  - err_flags[4]=1 and locked drops.
  - Pulse err_clr later with clean input: err_flags returns to 0.
- Frame with 524 lines:
  - At its v_fall, err_flags[2]=1 and last_frame_lines=524.
  - State remains ACQUIRE (locked=0).
- Coincident h_fall and v_fall: the frame following is still measured as 525 lines, with no err2.
- Assert reset for 1 cycle mid-frame while locked:
  - All outputs are 0 next cycle.
  - Relock requires two further v_fall edges.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sync/blank timing checker with lock, sticky errors and frame counter
// Optional active-pixel counter enabled by defining VGA_MON_ACTIVE_CNT_EN.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC_W = 96,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  RGB,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_pulse,
  output logic [4:0]  err_flags,
  output logic [15:0] frame_count,
  output logic [11:0] last_line_len,
  output logic [10:0] last_frame_lines
`ifdef VGA_MON_ACTIVE_CNT_EN
  ,
  output logic [19:0] active_pix_cnt
`endif
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_W_C = 12'(H_SYNC_W);
  localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_W_C = 11'(V_SYNC_W);

  state_t      state_q;
  logic        h_dly_q, v_dly_q, hv_q, fe_q;
  logic [11:0] hcnt_q, hwcnt_q;
  logic [10:0] vline_q, vwcnt_q;
  logic        locked_q, frame_pulse_q;
  logic [4:0]  err_flags_q;
  logic [15:0] frame_count_q;
  logic [11:0] last_line_len_q;
  logic [10:0] last_frame_lines_q;

  logic        h_fall, h_rise, v_fall, v_rise, any_err;
  logic [11:0] hcnt_d, hwcnt_d;
  logic [10:0] vline_d, vwcnt_d;
  logic [4:0]  err_now;

  assign h_fall = h_dly_q & ~h_sync;
  assign h_rise = ~h_dly_q & h_sync;
  assign v_fall = v_dly_q & ~v_sync;
  assign v_rise = ~v_dly_q & v_sync;

  // Saturating increments of every measurement counter.
  assign hcnt_d  = (hcnt_q  == 12'hFFF) ? hcnt_q  : hcnt_q  + 12'd1;
  assign hwcnt_d = (hwcnt_q == 12'hFFF) ? hwcnt_q : hwcnt_q + 12'd1;
  assign vline_d = (vline_q == 11'h7FF) ? vline_q : vline_q + 11'd1;
  assign vwcnt_d = (vwcnt_q == 11'h7FF) ? vwcnt_q : vwcnt_q + 11'd1;

  always_comb begin
    err_now = '0;
    if (state_q != SEARCH) begin
      err_now[0] = h_fall & hv_q & (hcnt_d != H_TOTAL_C);
      err_now[1] = h_rise & hv_q & (hwcnt_q != H_SYNC_W_C);
      err_now[2] = v_fall & (vline_q != V_TOTAL_C);
      err_now[3] = v_rise & (vwcnt_q != V_SYNC_W_C);
      err_now[4] = (RGB != 3'b000) & (~h_sync | ~v_sync);
    end
  end

  assign any_err = |err_now;

`ifdef VGA_MON_ACTIVE_CNT_EN
  logic [19:0] apc_q, active_pix_cnt_q;
  assign active_pix_cnt = active_pix_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      apc_q            <= '0;
      active_pix_cnt_q <= '0;
    end else if (v_fall) begin
      active_pix_cnt_q <= apc_q;
      apc_q            <= '0;
    end else if (RGB != 3'b000 && apc_q != 20'hFFFFF) begin
      apc_q <= apc_q + 20'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= SEARCH;
      h_dly_q            <= 1'b1;
      v_dly_q            <= 1'b1;
      hv_q               <= 1'b0;
      fe_q               <= 1'b0;
      hcnt_q             <= '0;
      hwcnt_q            <= '0;
      vline_q            <= '0;
      vwcnt_q            <= '0;
      locked_q           <= 1'b0;
      frame_pulse_q      <= 1'b0;
      err_flags_q        <= '0;
      frame_count_q      <= '0;
      last_line_len_q    <= '0;
      last_frame_lines_q <= '0;
    end else begin
      h_dly_q       <= h_sync;
      v_dly_q       <= v_sync;
      frame_pulse_q <= 1'b0;
      err_flags_q   <= (err_clr ? 5'b00000 : err_flags_q) | err_now;

      if (h_fall) begin
        hcnt_q          <= '0;
        last_line_len_q <= hcnt_d;
        hv_q            <= 1'b1;
      end else begin
        hcnt_q <= hcnt_d;
      end

      if (h_rise)       hwcnt_q <= '0;
      else if (!h_sync) hwcnt_q <= hwcnt_d;

      // An h_fall coincident with v_fall is the first line of the new frame.
      if (v_fall) begin
        last_frame_lines_q <= vline_q;
        vline_q            <= h_fall ? 11'd1 : 11'd0;
        vwcnt_q            <= h_fall ? 11'd1 : 11'd0;
      end else if (h_fall) begin
        vline_q <= vline_d;
        if (!v_sync) vwcnt_q <= vwcnt_d;
      end

      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_q <= ACQUIRE;
            fe_q    <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (v_fall) begin
            frame_pulse_q <= 1'b1;
            fe_q          <= 1'b0;
            if (!fe_q && !any_err) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (any_err) begin
            fe_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state_q       <= ACQUIRE;
            locked_q      <= 1'b0;
            fe_q          <= ~v_fall;
            frame_pulse_q <= v_fall;
          end else if (v_fall) begin
            frame_pulse_q <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign locked           = locked_q;
  assign frame_pulse      = frame_pulse_q;
  assign err_flags        = err_flags_q;
  assign frame_count      = frame_count_q;
  assign last_line_len    = last_line_len_q;
  assign last_frame_lines = last_frame_lines_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - frame-table and scoreboard bench for vga_sync_monitor on a reduced raster
module tb_vga_sync_monitor;
  // Reduced raster: 20 clk lines (12 active, sync at 14..17), 12 line frames (8 active, vsync lines 9..10).
  localparam int HT = 20, HSW = 4, VT = 12, VSW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1, h_sync = 1'b1, v_sync = 1'b1, err_clr = 1'b0;
  logic [2:0]  rgb = 3'b000;
  logic        locked, frame_pulse;
  logic [4:0]  err_flags;
  logic [15:0] frame_count;
  logic [11:0] last_line_len;
  logic [10:0] last_frame_lines;
`ifdef VGA_MON_ACTIVE_CNT_EN
  logic [19:0] active_pix_cnt;
`endif

  always #5 clk = ~clk;

  vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC_W(HSW), .V_TOTAL(VT), .V_SYNC_W(VSW)) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .RGB(rgb), .err_clr(err_clr),
    .locked(locked), .frame_pulse(frame_pulse), .err_flags(err_flags), .frame_count(frame_count),
    .last_line_len(last_line_len), .last_frame_lines(last_frame_lines)
`ifdef VGA_MON_ACTIVE_CNT_EN
    , .active_pix_cnt(active_pix_cnt)
`endif
  );

  typedef enum int {F_NONE, F_SHORT, F_RGB_SYNC, F_CLR, F_LESS, F_COINC, F_RESET} fault_t;
  typedef struct {
    fault_t     fault;
    bit         pulse;
    bit         lck;
    int         cnt;
    logic [4:0] err;
    int         lines;
  } vec_t;
  typedef struct {
    bit         lck;
    int         cnt;
    logic [4:0] err;
    int         lines;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, cur_row = -1;
  logic prev_v = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, cur_row, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (frame_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_frame_pulse", 32'(frame_pulse), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_locked", 32'(locked), 32'(e.lck));
        check("sb_frame_count", 32'(frame_count), 32'(e.cnt));
        check("sb_err_flags", 32'(err_flags), 32'(e.err));
        check("sb_last_frame_lines", 32'(last_frame_lines), 32'(e.lines));
        check("sb_last_line_len", 32'(last_line_len), 32'(HT));
      end
    end
  endtask

  function automatic logic vlevel(input int line, input int hpos, input bit coinc);
    if (coinc) return !((line == 9 && hpos >= 14) || line == 10 || (line == 11 && hpos < 14));
    return !(line == 9 || line == 10);
  endfunction

  task automatic run_frame(input vec_t v);
    for (int line = 0; line < VT; line++) begin
      if (v.fault == F_LESS && line == 7) continue;
      for (int hpos = 0; hpos < HT; hpos++) begin
        if (v.fault == F_SHORT && line == 3 && hpos == 19) continue;
        h_sync  = !(hpos >= 14 && hpos <= 17);
        v_sync  = vlevel(line, hpos, v.fault == F_COINC);
        rgb     = (line < 8 && hpos < 12) ? 3'b011 : 3'b000;
        if (v.fault == F_RGB_SYNC && line == 3 && hpos == 15) rgb = 3'b011;
        err_clr = (v.fault == F_CLR && line == 5 && hpos == 0);
        reset   = (v.fault == F_RESET && line == 4 && hpos == 5);
        if (prev_v && !v_sync && v.pulse) sb.push_back('{v.lck, v.cnt, v.err, v.lines});
        prev_v = v_sync;
        tick();
        if (v.fault == F_SHORT && line == 4 && hpos == 13)
          check("short_locked_before", 32'(locked), 32'd1);
        if (v.fault == F_SHORT && line == 4 && hpos == 14) begin
          check("short_locked_drop", 32'(locked), 32'd0);
          check("short_err0", 32'(err_flags[0]), 32'd1);
          check("short_line_len", 32'(last_line_len), 32'(HT - 1));
        end
        if (v.fault == F_RGB_SYNC && line == 3 && hpos == 15) begin
          check("rgb_err4", 32'(err_flags[4]), 32'd1);
          check("rgb_locked_drop", 32'(locked), 32'd0);
        end
        if (v.fault == F_CLR && line == 5 && hpos == 0)
          check("clr_err_flags", 32'(err_flags), 32'd0);
        if (v.fault == F_RESET && line == 4 && hpos == 5) begin
          check("rst_locked", 32'(locked), 32'd0);
          check("rst_frame_pulse", 32'(frame_pulse), 32'd0);
          check("rst_err_flags", 32'(err_flags), 32'd0);
          check("rst_frame_count", 32'(frame_count), 32'd0);
          check("rst_line_len", 32'(last_line_len), 32'd0);
          check("rst_frame_lines", 32'(last_frame_lines), 32'd0);
        end
        if (v.fault == F_RESET && line == 11 && hpos == 19)
          check("rst_no_lock_after_one_vfall", 32'(locked), 32'd0);
      end
    end
  endtask

  initial begin
    //           fault       pulse lck cnt err       lines
    vecs[0]  = '{F_NONE,     1'b0, 1'b0, 0, 5'b00000, 0};
    vecs[1]  = '{F_NONE,     1'b1, 1'b1, 0, 5'b00000, 12};
    vecs[2]  = '{F_NONE,     1'b1, 1'b1, 1, 5'b00000, 12};
    vecs[3]  = '{F_SHORT,    1'b1, 1'b0, 1, 5'b00001, 12};
    vecs[4]  = '{F_NONE,     1'b1, 1'b1, 1, 5'b00001, 12};
    vecs[5]  = '{F_RGB_SYNC, 1'b1, 1'b0, 1, 5'b10001, 12};
    vecs[6]  = '{F_CLR,      1'b1, 1'b1, 1, 5'b00000, 12};
    vecs[7]  = '{F_NONE,     1'b1, 1'b1, 2, 5'b00000, 12};
    vecs[8]  = '{F_LESS,     1'b1, 1'b0, 2, 5'b00100, 11};
    vecs[9]  = '{F_NONE,     1'b1, 1'b1, 2, 5'b00100, 12};
    vecs[10] = '{F_COINC,    1'b1, 1'b1, 3, 5'b00100, 12};
    vecs[11] = '{F_COINC,    1'b1, 1'b1, 4, 5'b00100, 12};
    vecs[12] = '{F_NONE,     1'b1, 1'b1, 5, 5'b00100, 12};
    vecs[13] = '{F_RESET,    1'b0, 1'b0, 0, 5'b00000, 0};
    vecs[14] = '{F_NONE,     1'b1, 1'b1, 0, 5'b00000, 12};
    vecs[15] = '{F_NONE,     1'b1, 1'b1, 1, 5'b00000, 12};

    for (int i = 0; i < 3; i++) tick();
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_frame_pulse", 32'(frame_pulse), 32'd0);
    check("reset_err_flags", 32'(err_flags), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    check("reset_line_len", 32'(last_line_len), 32'd0);
    check("reset_frame_lines", 32'(last_frame_lines), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cur_row = i;
      run_frame(vecs[i]);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_line_len", 32'(last_line_len), 32'(HT));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
